stopwatch_core: RTL and testbench

Timekeeping stage that directly feeds the 7-segment multiplexer. It holds the minutes and seconds count (00:00–59:59) and advances it on a 1 Hz enable. Debounced buttons drive run/pause and clear. An adjust mode lets the user set either field at 2 Hz. Outputs are binary minutes/seconds in the 6-bit format the display stage consumes, plus a blink flag for the field being adjusted.

---
 rtl/stopwatch_pkg.sv | 12 +
 rtl/mod_counter.sv | 30 +++
 rtl/stopwatch_core.sv | 118 +++++++++++
 tb/tb_stopwatch_core.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping stage.
package stopwatch_pkg;
    localparam int FIELD_W     = 6;
    localparam int DEF_MAX_MIN = 59;
    localparam int DEF_MAX_SEC = 59;

    typedef enum logic [1:0] {
        PAUSED  = 2'd0,
        RUNNING = 2'd1,
        ADJUST  = 2'd2
    } state_t;
endpackage

// File: rtl/mod_counter.sv
// Modulo-(MAX+1) field counter; synchronous clear beats increment.
module mod_counter
    import stopwatch_pkg::*;
#(
    parameter int MAX = DEF_MAX_SEC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    output logic [FIELD_W-1:0] q,
    output logic               at_max
);
    localparam logic [FIELD_W-1:0] MAX_Q = FIELD_W'(MAX);

    logic [FIELD_W-1:0] r_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= (r_q == MAX_Q) ? '0 : r_q + 1'b1;
        end
    end

    assign q      = r_q;
    assign at_max = (r_q == MAX_Q);
endmodule

// File: rtl/stopwatch_core.sv
// Minutes:seconds stopwatch with run/pause, clear and per-field adjust mode.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MAX_MIN = DEF_MAX_MIN,
    parameter int MAX_SEC = DEF_MAX_SEC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_1hz,
    input  logic               tick_2hz,
    input  logic               btn_pause,
    input  logic               btn_clear,
    input  logic               adj,
    input  logic               sel,
    output logic [FIELD_W-1:0] minutes,
    output logic [FIELD_W-1:0] seconds,
    output logic               blink,
    output logic               wrap
);
    state_t r_state;
    state_t w_state_nxt;
    logic   r_pause_prev;
    logic   r_clear_prev;
    logic   r_blink;
    logic   r_wrap;
    logic   w_pause_edge;
    logic   w_clear_edge;
    logic   w_sec_inc;
    logic   w_min_inc;
    logic   w_sec_max;
    logic   w_min_max;
    logic   w_blink_nxt;
    logic   w_wrap_nxt;

    assign w_pause_edge = btn_pause & ~r_pause_prev;
    assign w_clear_edge = btn_clear & ~r_clear_prev;

    // prev registers reset high so a button held through reset is not an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= PAUSED;
            r_pause_prev <= 1'b1;
            r_clear_prev <= 1'b1;
            r_blink      <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pause_prev <= btn_pause;
            r_clear_prev <= btn_clear;
            r_blink      <= w_blink_nxt;
            r_wrap       <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sec_inc   = 1'b0;
        w_min_inc   = 1'b0;
        w_blink_nxt = r_blink;
        w_wrap_nxt  = 1'b0;

        if (adj) begin
            w_state_nxt = ADJUST;
        end else if (r_state == ADJUST) begin
            w_state_nxt = PAUSED;
        end else if (w_pause_edge) begin
            w_state_nxt = (r_state == PAUSED) ? RUNNING : PAUSED;
        end

        // Ticks act on the current state; a clear edge drops them entirely
        case (r_state)
            RUNNING: begin
                if (tick_1hz) begin
                    w_sec_inc  = 1'b1;
                    w_min_inc  = w_sec_max;
                    w_wrap_nxt = w_sec_max & w_min_max & ~w_clear_edge;
                end
            end
            ADJUST: begin
                if (tick_2hz) begin
                    w_sec_inc = ~sel;
                    w_min_inc = sel;
                    if (!w_clear_edge) begin
                        w_blink_nxt = ~r_blink;
                    end
                end
            end
            default: begin
            end
        endcase

        if (w_state_nxt != ADJUST || r_state != ADJUST) begin
            w_blink_nxt = 1'b0;
        end
    end

    mod_counter #(.MAX(MAX_SEC)) u_sec (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clear_edge),
        .inc    (w_sec_inc),
        .q      (seconds),
        .at_max (w_sec_max)
    );

    mod_counter #(.MAX(MAX_MIN)) u_min (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_clear_edge),
        .inc    (w_min_inc),
        .q      (minutes),
        .at_max (w_min_max)
    );

    assign blink = r_blink;
    assign wrap  = r_wrap;
endmodule

// File: tb/tb_stopwatch_core.sv
// Self-checking bench for stopwatch_core: directed scenarios plus random stimulus vs. a behavioural model.
module tb_stopwatch_core;
    localparam int MM = 59;
    localparam int MS = 59;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz, tick_2hz, btn_pause, btn_clear, adj, sel;
    logic [5:0] minutes, seconds;
    logic       blink, wrap;

    stopwatch_core #(.MAX_MIN(MM), .MAX_SEC(MS)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_1hz  (tick_1hz),
        .tick_2hz  (tick_2hz),
        .btn_pause (btn_pause),
        .btn_clear (btn_clear),
        .adj       (adj),
        .sel       (sel),
        .minutes   (minutes),
        .seconds   (seconds),
        .blink     (blink),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 = paused, 1 = running, 2 = adjusting
    int m_min, m_sec, m_mode, m_prev_p, m_prev_c, m_blink, m_wrap;
    int wrap_cnt, tog_cnt;
    logic last_blink;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_min = 0; m_sec = 0; m_mode = 0; m_blink = 0; m_wrap = 0;
        m_prev_p = 1; m_prev_c = 1;
    endtask

    task automatic model_edge();
        int pe, ce, nmode, tot;
        pe = (btn_pause && !m_prev_p) ? 1 : 0;
        ce = (btn_clear && !m_prev_c) ? 1 : 0;
        m_prev_p = int'(btn_pause);
        m_prev_c = int'(btn_clear);
        m_wrap = 0;
        if (adj)              nmode = 2;
        else if (m_mode == 2) nmode = 0;
        else if (pe)          nmode = (m_mode == 0) ? 1 : 0;
        else                  nmode = m_mode;
        if (ce) begin
            m_min = 0; m_sec = 0;
        end else if (m_mode == 1 && tick_1hz) begin
            tot = m_min * (MS + 1) + m_sec + 1;
            if (tot == (MM + 1) * (MS + 1)) begin
                tot = 0; m_wrap = 1;
            end
            m_min = tot / (MS + 1);
            m_sec = tot % (MS + 1);
        end else if (m_mode == 2 && tick_2hz) begin
            if (sel) m_min = (m_min + 1) % (MM + 1);
            else     m_sec = (m_sec + 1) % (MS + 1);
        end
        if (nmode != 2 || m_mode != 2) m_blink = 0;
        else if (tick_2hz && !ce)      m_blink = 1 - m_blink;
        m_mode = nmode;
    endtask

    // One clock: model advances on the edge, outputs are compared 1 ns later
    task automatic step();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_edge();
        #1;
        check("cyc_minutes", 32'(minutes), 32'(m_min));
        check("cyc_seconds", 32'(seconds), 32'(m_sec));
        check("cyc_blink",   32'(blink),   32'(m_blink));
        check("cyc_wrap",    32'(wrap),    32'(m_wrap));
        if (wrap === 1'b1) wrap_cnt++;
        if (blink !== last_blink) tog_cnt++;
        last_blink = blink;
    endtask

    task automatic pulse1(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1hz = 1'b1; step();
            tick_1hz = 1'b0; step();
        end
    endtask

    task automatic pulse2(input int n);
        for (int i = 0; i < n; i++) begin
            tick_2hz = 1'b1; step();
            tick_2hz = 1'b0; step();
        end
    endtask

    task automatic press_pause();
        btn_pause = 1'b1; step();
        btn_pause = 1'b0; step();
    endtask

    task automatic press_clear();
        btn_clear = 1'b1; step();
        btn_clear = 1'b0; step();
    endtask

    // Leaves the core PAUSED showing mn:sc
    task automatic set_time(input int mn, input int sc);
        press_clear();
        adj = 1'b1; step();
        sel = 1'b1; pulse2(mn);
        sel = 1'b0; pulse2(sc);
        adj = 1'b0; step();
    endtask

    task automatic expect_time(input string name, input int mn, input int sc);
        check({name, "_min"}, 32'(minutes), 32'(mn));
        check({name, "_sec"}, 32'(seconds), 32'(sc));
    endtask

    initial begin
        rst = 1'b0; tick_1hz = 1'b0; tick_2hz = 1'b0;
        btn_pause = 1'b0; btn_clear = 1'b0; adj = 1'b0; sel = 1'b0;
        wrap_cnt = 0; tog_cnt = 0; last_blink = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 3; i++) step();
        expect_time("reset", 0, 0);
        check("reset_blink", 32'(blink), 0);
        check("reset_wrap",  32'(wrap),  0);
        rst = 1'b1;
        step();

        // Run 75 seconds
        press_pause();
        wrap_cnt = 0;
        pulse1(75);
        expect_time("run75", 1, 15);
        check("run75_nowrap", 32'(wrap_cnt), 0);

        // Pause freezes the count, resume continues it
        press_pause();
        pulse1(10);
        expect_time("paused", 1, 15);
        press_pause();
        pulse1(1);
        expect_time("resumed", 1, 16);

        // Clear coincident with a tick drops the tick
        press_clear();
        expect_time("clear", 0, 0);
        pulse1(30);
        expect_time("at30", 0, 30);
        tick_1hz = 1'b1; btn_clear = 1'b1; step();
        expect_time("clr_tick", 0, 0);
        tick_1hz = 1'b0; btn_clear = 1'b0; step();

        // Roll over from 59:59 to 00:00 with a single wrap pulse
        set_time(59, 58);
        expect_time("preload", 59, 58);
        press_pause();
        wrap_cnt = 0;
        pulse1(1);
        expect_time("pre_wrap", 59, 59);
        tick_1hz = 1'b1; step();
        expect_time("wrapped", 0, 0);
        check("wrap_pulse", 32'(wrap), 1);
        tick_1hz = 1'b0; step();
        check("wrap_low", 32'(wrap), 0);
        check("wrap_count", 32'(wrap_cnt), 1);

        // Clear beats wrap at 59:59
        set_time(59, 59);
        press_pause();
        wrap_cnt = 0;
        tick_1hz = 1'b1; btn_clear = 1'b1; step();
        expect_time("clr_at_max", 0, 0);
        check("clr_at_max_wrap", 32'(wrap), 0);
        tick_1hz = 1'b0; btn_clear = 1'b0; step();
        check("clr_at_max_cnt", 32'(wrap_cnt), 0);

        // Adjust minutes 61 times: wraps to 01 with no carry, blink toggles each tick
        press_clear();
        adj = 1'b1; sel = 1'b1; step();
        check("adj_entry_blink", 32'(blink), 0);
        tog_cnt = 0;
        pulse2(61);
        expect_time("adj61", 1, 0);
        check("adj61_toggles", 32'(tog_cnt), 61);
        adj = 1'b0; step();
        check("adj_exit_blink", 32'(blink), 0);

        // Randomised phase, including back-to-back ticks
        set_time(59, 40);
        for (int i = 0; i < 4000; i++) begin
            tick_1hz = ($urandom_range(0, 2) == 0);
            tick_2hz = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 11) == 0) btn_pause = ~btn_pause;
            if ($urandom_range(0, 59) == 0) btn_clear = ~btn_clear;
            if ($urandom_range(0, 79) == 0) adj = ~adj;
            if ($urandom_range(0, 15) == 0) sel = ~sel;
            step();
        end
        tick_1hz = 1'b0; tick_2hz = 1'b0; btn_pause = 1'b0;
        btn_clear = 1'b0; adj = 1'b0; sel = 1'b0;
        step(); step();

        // Asynchronous reset mid-run
        if (m_mode != 1) press_pause();
        pulse1(3);
        tick_1hz = 1'b1;
        rst = 1'b0;
        #2;
        expect_time("async_rst", 0, 0);
        check("async_rst_blink", 32'(blink), 0);
        check("async_rst_wrap",  32'(wrap),  0);
        model_reset();
        tick_1hz = 1'b0;
        step();

        // Pause button held through reset release is not an edge
        btn_pause = 1'b1;
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) step();
        btn_pause = 1'b0;
        pulse1(5);
        expect_time("held_btn", 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, limit %0d ns", 2000000);
        $fatal(1);
    end
endmodule
